tdm_demux: RTL and testbench

Receive end of the team's mux-based time-division link: a 1-to-NUM_CH demultiplexer.
- Accepts a single time-multiplexed data stream, one slot per valid beat, with slot 0 of each frame flagged by in_sof.
- Steers each slot into its own registered channel output.
- Tracks frame alignment and flags sync errors.
- Sits after the link mux / serial front end and feeds per-channel consumers.

---
 rtl/tdm_demux_if.sv | 25 ++
 rtl/tdm_demux.sv | 127 ++++++++++++
 tb/tb_tdm_demux.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundles the slot stream and the per-channel outputs of tdm_demux.
// master = upstream driver / observer, slave = the demultiplexer itself.
interface tdm_demux_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8
);
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_sof;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic [NUM_CH-1:0]        out_valid;
   logic                     frame_done;
   logic                     sync_err;
   logic                     locked;

   modport master (
      output in_valid, in_data, in_sof,
      input  out_data, out_valid, frame_done, sync_err, locked
   );

   modport slave (
      input  in_valid, in_data, in_sof,
      output out_data, out_valid, frame_done, sync_err, locked
   );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: 1-to-NUM_CH TDM demultiplexer with frame alignment tracking.
// Optional macro TDM_DEMUX_FRAME_LATCH_EN: slot words collect in a shadow
// buffer and reach out_data only as a complete frame, all channels at once.
module tdm_demux #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   tdm_demux_if.slave   bus
);
   localparam int unsigned     SW   = $clog2(NUM_CH);
   localparam logic [SW-1:0]   LAST = SW'(NUM_CH - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   slot_cnt, slot_nxt;
   logic [SW-1:0]   wr_ch;
   logic            wr_en;
   logic            err_nxt;
   logic            last_nxt;

   // State and slot position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         slot_cnt <= '0;
      end else begin
         state    <= state_nxt;
         slot_cnt <= slot_nxt;
      end
   end

   // Next-state, slot position and write steering for the current beat
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot_cnt;
      wr_en     = 1'b0;
      wr_ch     = '0;
      err_nxt   = 1'b0;
      if (bus.in_valid) begin
         unique case (state)
            HUNT: begin
               if (bus.in_sof) begin
                  wr_en     = 1'b1;
                  slot_nxt  = SW'(1);
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (bus.in_sof) begin
                  // an early SOF restarts the frame at slot 0
                  err_nxt  = (slot_cnt != '0);
                  wr_en    = 1'b1;
                  slot_nxt = SW'(1);
               end else if (slot_cnt == '0) begin
                  // missing SOF: drop the beat and re-acquire
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
               end else begin
                  wr_en    = 1'b1;
                  wr_ch    = slot_cnt;
                  slot_nxt = (slot_cnt == LAST) ? '0 : slot_cnt + 1'b1;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
      last_nxt = wr_en && (wr_ch == LAST);
   end

   // Status flags: pulses plus locked mirroring the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.frame_done <= 1'b0;
         bus.sync_err   <= 1'b0;
         bus.locked     <= 1'b0;
      end else begin
         bus.frame_done <= last_nxt;
         bus.sync_err   <= err_nxt;
         bus.locked     <= (state_nxt == LOCKED);
      end
   end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   logic [NUM_CH*DATA_W-1:0] shadow, shadow_upd;

   // Shadow contents including the word being written this cycle
   always_comb begin
      shadow_upd = shadow;
      if (wr_en) shadow_upd[wr_ch*DATA_W +: DATA_W] = bus.in_data;
   end

   // Collect slots in the shadow; publish only a completed frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow        <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= '0;
      end else begin
         if (wr_en) shadow <= shadow_upd;
         if (last_nxt) bus.out_data <= shadow_upd;
         bus.out_valid <= last_nxt ? '1 : '0;
      end
   end
`else
   logic [NUM_CH-1:0] wr_onehot;

   // Channel strobe for the slot being written
   always_comb begin
      wr_onehot = '0;
      if (wr_en) wr_onehot[wr_ch] = 1'b1;
   end

   // Per-slot update of the addressed channel register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_data  <= '0;
         bus.out_valid <= '0;
      end else begin
         if (wr_en) bus.out_data[wr_ch*DATA_W +: DATA_W] <= bus.in_data;
         bus.out_valid <= wr_onehot;
      end
   end
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed-vector scoreboard bench for tdm_demux.
// Honours TDM_DEMUX_FRAME_LATCH_EN the same way as the design.
module tb_tdm_demux;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DATA_W = 8;

   typedef struct packed {
      logic [3:0]  v;
      logic [31:0] d;
      logic        fd;
      logic        err;
      logic        lk;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];

   tdm_demux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // One beat; dd = per-slot out_data expectation, dl = frame-latched expectation
   task automatic beat(input logic sof, input logic [7:0] w, input logic [3:0] ev,
                       input logic [31:0] dd, input logic [31:0] dl,
                       input logic fd, input logic err, input logic lk);
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_sof   = sof;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      e = '{v: (fd ? 4'hF : 4'h0), d: dl, fd: fd, err: err, lk: lk};
      if (fd || err) q.push_back(e);
`else
      e = '{v: ev, d: dd, fd: fd, err: err, lk: lk};
      if (ev != 4'h0 || err) q.push_back(e);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_sof   = 1'b0;
         bus.in_data  = 8'h00;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"},   64'(bus.out_data),   64'h0);
      chk({tag, "_valid"},  64'(bus.out_valid),  64'h0);
      chk({tag, "_fdone"},  64'(bus.frame_done), 64'h0);
      chk({tag, "_serr"},   64'(bus.sync_err),   64'h0);
      chk({tag, "_locked"}, 64'(bus.locked),     64'h0);
   endtask

   // Monitor: every output event must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (bus.out_valid != '0 || bus.sync_err || bus.frame_done)) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_event: valid=0x%0h err=%0b fdone=%0b with nothing expected",
                        bus.out_valid, bus.sync_err, bus.frame_done);
            end else begin
               e = q.pop_front();
               chk("ev_valid",  64'(bus.out_valid),  64'(e.v));
               chk("ev_data",   64'(bus.out_data),   64'(e.d));
               chk("ev_fdone",  64'(bus.frame_done), 64'(e.fd));
               chk("ev_serr",   64'(bus.sync_err),   64'(e.err));
               chk("ev_locked", 64'(bus.locked),     64'(e.lk));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = 8'h00;
      #2 rst_n = 1'b0;
      #20 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Unaligned beats are ignored until an SOF arrives
      beat(0, 8'hAA, 4'h0, 32'h0, 32'h0, 0, 0, 0);
      beat(0, 8'hBB, 4'h0, 32'h0, 32'h0, 0, 0, 0);
      idle(1);
      chk("hunt_data",   64'(bus.out_data), 64'h0);
      chk("hunt_locked", 64'(bus.locked),   64'h0);
      beat(1, 8'h01, 4'h1, 32'h0000_0001, 32'h0, 0, 0, 1);
      beat(0, 8'h02, 4'h2, 32'h0000_0201, 32'h0, 0, 0, 1);
      beat(0, 8'h03, 4'h4, 32'h0003_0201, 32'h0, 0, 0, 1);
      beat(0, 8'h04, 4'h8, 32'h0403_0201, 32'h0403_0201, 1, 0, 1);

      // Clean frame
      beat(1, 8'h11, 4'h1, 32'h0403_0211, 32'h0, 0, 0, 1);
      beat(0, 8'h22, 4'h2, 32'h0403_2211, 32'h0, 0, 0, 1);
      beat(0, 8'h33, 4'h4, 32'h0433_2211, 32'h0, 0, 0, 1);
      beat(0, 8'h44, 4'h8, 32'h4433_2211, 32'h4433_2211, 1, 0, 1);

      // Frame with an in-frame gap
      beat(1, 8'h55, 4'h1, 32'h4433_2255, 32'h0, 0, 0, 1);
      beat(0, 8'h66, 4'h2, 32'h4433_6655, 32'h0, 0, 0, 1);
      idle(3);
      beat(0, 8'h77, 4'h4, 32'h4477_6655, 32'h0, 0, 0, 1);
      beat(0, 8'h88, 4'h8, 32'h8877_6655, 32'h8877_6655, 1, 0, 1);

      // Early SOF on slot 2 restarts the frame
      beat(1, 8'h10, 4'h1, 32'h8877_6610, 32'h0, 0, 0, 1);
      beat(0, 8'h20, 4'h2, 32'h8877_2010, 32'h0, 0, 0, 1);
      beat(1, 8'h30, 4'h1, 32'h8877_2030, 32'h8877_6655, 0, 1, 1);
      beat(0, 8'h40, 4'h2, 32'h8877_4030, 32'h0, 0, 0, 1);
      beat(0, 8'h50, 4'h4, 32'h8850_4030, 32'h0, 0, 0, 1);
      beat(0, 8'h60, 4'h8, 32'h6050_4030, 32'h6050_4030, 1, 0, 1);

      // Long frame: fifth beat without SOF drops lock and is discarded
      beat(1, 8'hA1, 4'h1, 32'h6050_40A1, 32'h0, 0, 0, 1);
      beat(0, 8'hA2, 4'h2, 32'h6050_A2A1, 32'h0, 0, 0, 1);
      beat(0, 8'hA3, 4'h4, 32'h60A3_A2A1, 32'h0, 0, 0, 1);
      beat(0, 8'hA4, 4'h8, 32'hA4A3_A2A1, 32'hA4A3_A2A1, 1, 0, 1);
      beat(0, 8'hA5, 4'h0, 32'hA4A3_A2A1, 32'hA4A3_A2A1, 0, 1, 0);
      idle(1);
      chk("lost_locked", 64'(bus.locked), 64'h0);

      // Reset asserted mid-frame
      beat(1, 8'hB1, 4'h1, 32'hA4A3_A2B1, 32'h0, 0, 0, 1);
      beat(0, 8'hB2, 4'h2, 32'hA4A3_B2B1, 32'h0, 0, 0, 1);
      idle(2);
      #2 rst_n = 1'b0;
      #1 chk_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      // After release the stream must realign on SOF
      beat(0, 8'hC1, 4'h0, 32'h0, 32'h0, 0, 0, 0);
      idle(1);
      chk("post_rst_data",   64'(bus.out_data), 64'h0);
      chk("post_rst_locked", 64'(bus.locked),   64'h0);
      beat(1, 8'hD1, 4'h1, 32'h0000_00D1, 32'h0, 0, 0, 1);
      idle(2);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      chk("final_data", 64'(bus.out_data), 64'h0);
`else
      chk("final_data", 64'(bus.out_data), 64'h0000_00D1);
`endif
      chk("final_locked", 64'(bus.locked), 64'h1);
      idle(3);
      chk("sb_drain", 64'(q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
